// File: rtl/ram_arbiter_2m.sv
// Two-master arbiter in front of a single-port 32-bit block RAM.
// Fixed three-cycle handshake: IDLE -> ACCESS -> RESP.
module ram_arbiter_2m #(
  parameter int AW         = 12,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          m0_valid,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic          m0_ready,
  output logic [31:0]   m0_rdata,
  input  logic          m1_valid,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic          m1_ready,
  output logic [31:0]   m1_rdata,
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_we,
  input  logic [31:0]   ram_rdata,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0] state;
  logic       last;
  logic       pick1;
  logic       acc;
  logic       rsp;
  logic       unused_addr;

  // On a tie, the master not served last wins unless master 0 has priority.
  always_comb begin
    pick1 = 1'b0;
    if (m0_valid && m1_valid)
      pick1 = FIXED_PRIO ? 1'b0 : !last;
    else
      pick1 = m1_valid;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      grant <= 2'b00;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant <= pick1 ? 2'b10 : 2'b01;
            state <= ACCESS;
          end
        end
        ACCESS: state <= RESP;
        RESP: begin
          last  <= grant[1];
          grant <= 2'b00;
          state <= IDLE;
        end
        default: begin
          grant <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

  assign acc  = (state == ACCESS);
  assign rsp  = (state == RESP);
  assign busy = (state != IDLE);

  assign ram_en = acc;

  assign ram_addr =
    !acc     ? '0 :
    grant[1] ? m1_addr[AW+1:2] :
               m0_addr[AW+1:2];

  assign ram_wdata =
    !acc     ? 32'h0 :
    grant[1] ? m1_wdata :
               m0_wdata;

  assign ram_we =
    !acc     ? 4'h0 :
    grant[1] ? m1_wstrb :
               m0_wstrb;

  assign m0_ready = rsp & grant[0];
  assign m1_ready = rsp & grant[1];

  assign m0_rdata = m0_ready ? ram_rdata : 32'h0;
  assign m1_rdata = m1_ready ? ram_rdata : 32'h0;

  // Byte-offset and high address bits are decoded upstream.
  assign unused_addr = ^{m0_addr[31:AW+2], m0_addr[1:0],
                         m1_addr[31:AW+2], m1_addr[1:0]};

endmodule

// File: tb/tb_ram_arbiter_2m.sv
// Bench for ram_arbiter_2m: directed and random traffic against a
// transaction-level memory model, plus a fixed-priority instance.
module tb_ram_arbiter_2m;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic [1:0]  grant;
  logic        busy;

  logic        f_m0_valid, f_m1_valid;
  logic        f_m0_ready, f_m1_ready;
  logic [31:0] f_m1_rdata;
  logic [1:0]  f_grant;
  logic        f_busy;
  logic [31:0] f_unused_m0_rdata;
  logic        f_unused_en;
  logic [11:0] f_unused_addr;
  logic [31:0] f_unused_wdata;
  logic [3:0]  f_unused_we;

  ram_arbiter_2m #(.AW(12), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata),
    .grant(grant), .busy(busy)
  );

  ram_arbiter_2m #(.AW(12), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .resetn(resetn),
    .m0_valid(f_m0_valid), .m0_addr(32'h0),
    .m0_wdata(32'h0), .m0_wstrb(4'h0),
    .m0_ready(f_m0_ready), .m0_rdata(f_unused_m0_rdata),
    .m1_valid(f_m1_valid), .m1_addr(32'h4),
    .m1_wdata(32'h0), .m1_wstrb(4'h0),
    .m1_ready(f_m1_ready), .m1_rdata(f_m1_rdata),
    .ram_en(f_unused_en), .ram_addr(f_unused_addr),
    .ram_wdata(f_unused_wdata), .ram_we(f_unused_we),
    .ram_rdata(32'h5A5A_0001),
    .grant(f_grant), .busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-lane BRAM with registered, read-first output.
  logic [31:0] ram [0:4095];
  logic        ld;
  logic [11:0] ld_idx;
  logic [31:0] ld_val;

  always @(posedge clk) begin
    if (ld) begin
      ram[ld_idx] <= ld_val;
    end else if (ram_en) begin
      ram_rdata <= ram[ram_addr];
      for (int i = 0; i < 4; i++)
        if (ram_we[i])
          ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  logic [31:0] model [0:4095];
  int          last_ref;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int m,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0] s);
    if (m == 1) begin
      m1_valid = 1'b1; m1_addr = a;
      m1_wdata = d;    m1_wstrb = s;
    end else begin
      m0_valid = 1'b1; m0_addr = a;
      m0_wdata = d;    m0_wstrb = s;
    end
  endtask

  task automatic rand_req(input int m);
    logic [31:0] a;
    logic [3:0]  s;
    a = ($urandom & 32'hFFFF_C000)
      | (32'($urandom_range(0, 15)) << 2)
      | 32'($urandom_range(0, 3));
    s = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
    set_req(m, a, $urandom, s);
  endtask

  // Call #1 after a posedge with the DUT idle and a request up.
  task automatic serve(output int w,
                       output logic [31:0] rd,
                       output logic [11:0] ao);
    logic [31:0] a, d, mask;
    logic [3:0]  s;
    logic [11:0] idx;
    logic [31:0] og;
    if (m0_valid && m1_valid) w = 1 - last_ref;
    else w = m1_valid ? 1 : 0;
    a  = (w == 1) ? m1_addr  : m0_addr;
    d  = (w == 1) ? m1_wdata : m0_wdata;
    s  = (w == 1) ? m1_wstrb : m0_wstrb;
    og = (w == 1) ? 32'd2 : 32'd1;
    idx = a[13:2];
    @(negedge clk);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_en", 32'(ram_en), 32'd0);
    chk("idle_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    chk("acc_en", 32'(ram_en), 32'd1);
    chk("acc_addr", 32'(ram_addr), 32'(idx));
    chk("acc_we", 32'(ram_we), 32'(s));
    chk("acc_wdata", ram_wdata, d);
    chk("acc_grant", 32'(grant), og);
    chk("acc_rdy", 32'({m1_ready, m0_ready}), 32'd0);
    ao = ram_addr;
    @(negedge clk);
    chk("rsp_rdy", 32'({m1_ready, m0_ready}), og);
    chk("rsp_busy", 32'(busy), 32'd1);
    chk("rsp_other_rdata",
        (w == 1) ? m0_rdata : m1_rdata, 32'h0);
    rd = (w == 1) ? m1_rdata : m0_rdata;
    if (s == 4'h0) chk("rsp_rdata", rd, model[idx]);
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    model[idx] = (model[idx] & ~mask) | (d & mask);
    last_ref = w;
    @(posedge clk); #1;
    if (w == 1) m1_valid = 1'b0;
    else m0_valid = 1'b0;
  endtask

  initial begin
    int          w;
    int          got;
    logic [31:0] rd;
    logic [11:0] ao;

    resetn = 1'b0;
    ld = 1'b0; ld_idx = '0; ld_val = '0;
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    f_m0_valid = 0; f_m1_valid = 0;
    last_ref = 1;
    for (int i = 0; i < 4096; i++) model[i] = 32'h0;
    model[5] = 32'hDEAD_BEEF;

    @(posedge clk); #1;
    ld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ld_idx = 12'(i);
      ld_val = (i == 5) ? 32'hDEAD_BEEF : 32'h0;
      @(posedge clk); #1;
    end
    ld = 1'b0;

    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_en", 32'(ram_en), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", ram_wdata, 32'h0);
    chk("rst_fp_grant", 32'(f_grant), 32'd0);

    @(posedge clk); #1;
    resetn = 1'b1;

    // Both masters hold requests: strict alternation from m0.
    set_req(0, 32'h14, 32'h0, 4'h0);
    set_req(1, 32'h20, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      serve(w, rd, ao);
      chk("alt_order", 32'(w), 32'(k % 2));
      if (k < 3) begin
        if (w == 1) set_req(1, 32'h20, 32'h0, 4'h0);
        else set_req(0, 32'h14, 32'h0, 4'h0);
      end
    end
    serve(w, rd, ao);
    chk("single_who", 32'(w), 32'd0);
    chk("single_rd", rd, 32'hDEAD_BEEF);

    set_req(1, 32'h20, 32'h1122_3344, 4'b0100);
    serve(w, rd, ao);
    set_req(1, 32'h20, 32'h0, 4'h0);
    serve(w, rd, ao);
    chk("byte_rd", rd, 32'h0022_0000);

    set_req(0, 32'h4000_0008, 32'hCAFE_F00D, 4'hF);
    serve(w, rd, ao);
    chk("wrap_addr", 32'(ao), 32'd2);
    set_req(0, 32'h8, 32'h0, 4'h0);
    serve(w, rd, ao);
    chk("wrap_rd", rd, 32'hCAFE_F00D);

    for (int it = 0; it < 40; it++) begin
      if (!m0_valid && $urandom_range(0, 1) == 1) rand_req(0);
      if (!m1_valid && $urandom_range(0, 1) == 1) rand_req(1);
      if (!m0_valid && !m1_valid)
        rand_req(int'($urandom_range(0, 1)));
      serve(w, rd, ao);
    end
    for (int k = 0; k < 2; k++)
      if (m0_valid || m1_valid) serve(w, rd, ao);

    // Reset landing in ACCESS aborts the access silently.
    set_req(0, 32'h14, 32'h0, 4'h0);
    set_req(1, 32'h20, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("ar_acc_en", 32'(ram_en), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_en", 32'(ram_en), 32'd0);
    chk("ar_we", 32'(ram_we), 32'd0);
    chk("ar_addr", 32'(ram_addr), 32'd0);
    chk("ar_wdata", ram_wdata, 32'h0);
    chk("ar_grant", 32'(grant), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_rdy", 32'({m1_ready, m0_ready}), 32'd0);
    m0_valid = 1'b0;
    @(negedge clk);
    chk("ar_no_rdy", 32'({m1_ready, m0_ready}), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    last_ref = 1;
    serve(w, rd, ao);
    chk("ar_m1_served", 32'(w), 32'd1);

    // Fixed priority: m0 always wins, m1 only once m0 drops.
    f_m0_valid = 1'b1;
    f_m1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int c = 0; c < 6 && got == 0; c++) begin
        @(negedge clk);
        chk("fp_no_m1_grant", 32'(f_grant[1]), 32'd0);
        if (f_m0_ready || f_m1_ready) got = 1;
      end
      chk("fp_m0_served",
          32'({f_m1_ready, f_m0_ready}), 32'd1);
    end
    @(posedge clk); #1;
    f_m0_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 3 && got == 0; c++) begin
      @(negedge clk);
      if (f_m1_ready) got = 1;
    end
    chk("fp_m1_within3", 32'(got), 32'd1);
    chk("fp_m1_rdata", f_m1_rdata, 32'h5A5A_0001);
    chk("fp_busy", 32'(f_busy), 32'd1);
    @(posedge clk); #1;
    f_m1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter_2m.md
Name: ram_arbiter_2m

Overview:
- Two-master arbiter that shares the single-port 32-bit block RAM (four byte-lane BRAMs, one-cycle registered read) between the CPU native memory bus (master 0) and a second native-protocol master such as a UART loader or DMA engine (master 1).
- Sits between the masters and the RAM. It serialises accesses, gates the RAM enable and byte write strobes, and steers read data and the ready pulse back to the granted master.
- Uses round-robin arbitration, or fixed priority to master 0 when selected by parameter.

Parameters:
- AW, 12, RAM word-address width; the RAM word address is taken from m*_addr[AW+1:2].
- FIXED_PRIO, 0, 0 = round robin; 1 = master 0 always wins a tie.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m0_valid  in  1  master 0 request; held until m0_ready
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes; 0 = read
- m0_ready  out  1  master 0 completion pulse
- m0_rdata  out  32  master 0 read data, valid with m0_ready
- m1_valid  in  1  master 1 request
- m1_addr  in  32  master 1 byte address
- m1_wdata  in  32  master 1 write data
- m1_wstrb  in  4  master 1 byte strobes
- m1_ready  out  1  master 1 completion pulse
- m1_rdata  out  32  master 1 read data
- ram_en  out  1  RAM enable
- ram_addr  out  AW  RAM word address
- ram_wdata  out  32  RAM write data
- ram_we  out  4  RAM byte write enables
- ram_rdata  in  32  RAM read data, valid one cycle after ram_en
- grant  out  2  one-hot current owner, 00 when idle
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, ACCESS, RESP. All state, grant and ready registers are cleared asynchronously by resetn=0.
- Reset values:
  - state=IDLE, grant=00, last=1 (so master 0 wins the first tie), busy=0.
  - m0_ready=m1_ready=0, m*_rdata=0.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- IDLE:
  - With no m*_valid, stay in IDLE.
  - With exactly one m*_valid, grant that master.
  - With both valid: FIXED_PRIO=1 grants m0. FIXED_PRIO=0 grants the master that was not `last`.
  - The grant is registered and the FSM moves to ACCESS. The RAM is not driven in IDLE.
- ACCESS (exactly one cycle):
  - ram_en=1, ram_addr=granted addr[AW+1:2], ram_wdata=granted wdata, ram_we=granted wstrb.
  - Next state is RESP.
- RESP (exactly one cycle):
  - Granted m*_ready=1 and m*_rdata=ram_rdata. For writes, rdata is don't-care and is driven as ram_rdata.
  - last <= granted index, grant <= 00, next state IDLE.
- Latency is fixed: valid sampled in IDLE at cycle N, then ACCESS at N+1, ready at N+2.
  - Throughput is one access per 3 cycles.
  - Back-to-back requests from both masters alternate under round robin.
- Non-granted master: ready=0, rdata=0. It may hold valid indefinitely and no request is dropped.
- Ready is a single-cycle pulse. It never asserts for a master whose valid was low when the grant was taken.
- A master deasserting valid while granted is a protocol violation. The access still completes and the ready pulse is still issued.
- Address bits above AW+1 are ignored; addresses wrap modulo 2^AW words. Address decode is done upstream.
- ram_en, ram_we and ram_addr are combinational from state and grant. ram_we is nonzero only in ACCESS.
- Simultaneous new request and RESP: requests are evaluated only in IDLE, so the new request waits one cycle.
- Reset mid-operation aborts the access with no ready pulse. A write already issued in ACCESS may have landed in the RAM.

Test Plan:
- Single read: preload word 5 = 0xDEADBEEF; m0 reads 0x14 → ram_en high one cycle at N+1 with ram_addr=5, ram_we=0; m0_ready at N+2 with m0_rdata=0xDEADBEEF; m1_ready stays 0.
- Byte write then read: m1 writes 0x11223344 to 0x20 with wstrb=0100; a prior word of 0 → readback of 0x20 returns 0x00220000.
- Simultaneous after reset: m0 and m1 both valid → m0 served first (ready at cycle 2), m1 next (ready at cycle 5); both held continuously → grants alternate m0, m1, m0, m1.
- FIXED_PRIO=1 with both valid continuously → m0 granted every time and m1 never granted; drop m0_valid → m1 served within 3 cycles.
- Async reset asserted in ACCESS → all outputs at reset values immediately without waiting for clk, no ready pulse; after release, a pending m1 request is served normally.
- Address wrap (AW=12): m0 writes 0x4000_0008 → ram_addr=2.
